debounce_timer_arbiter: RTL and testbench
=========================================

// Module: debounce_timer_arbiter
// PURPOSE
//  Debounces NKEYS switch inputs with a single shared TW-bit debounce timer.
//  This replaces one timer per key.
//  A round-robin arbiter lends the timer to one key at a time: any key whose synchronised input differs from its debounced level.
//  Sits between the raw board buttons/switches and the UI/control FSMs, e.g. the screen-adjust logic.
// PARAMETERS
//  NKEYS  4   number of switch inputs (>=2)
//  TW     19  timer width; stable time = 2^TW clocks (19 -> ~10.5 ms at 50 MHz)
//  OW     $clog2(NKEYS)  owner-index width (derived, localparam)
// PORTS
//  clk            in   1      system clock, all logic on rising edge
//  rst            in   1      synchronous reset, active-high
//  sw             in   NKEYS  raw asynchronous switch inputs
//  db_level       out  NKEYS  debounced level per key (registered)
//  db_tick        out  NKEYS  1-cycle pulse when db_level[i] goes 0->1
//  db_rel_tick    out  NKEYS  1-cycle pulse when db_level[i] goes 1->0
//  timer_busy     out  1      shared timer currently granted
//  timer_owner    out  OW     index of key holding timer (valid when timer_busy)
// BEHAVIOUR
//  Reset (clk edge with rst=1)
//   - Clears: synchronisers, db_level, db_tick, db_rel_tick, timer, timer_busy, timer_owner, rr pointer.
//   - Reset mid-count aborts everything in that one edge; no tick is emitted.
//  Sync
//   - 2-flop synchroniser per key -> s[i].
//   - mismatch[i] = s[i] ^ db_level[i]; this is key i's timer request.
//  Arbitration (timer_busy=0)
//   - Search starts at ptr and moves upward modulo NKEYS; the first i with mismatch[i] wins.
//   - Grant edge: timer<=0, timer_owner<=i, timer_busy<=1, ptr<=(i+1)%NKEYS.
//   - No mismatch: idle, ptr unchanged.
//  Owning (timer_busy=1, o=timer_owner)
//   - mismatch[o]=0 (bounce/revert): timer_busy<=0 at that edge; no level change, no tick.
//   - mismatch[o]=1 and timer!=all-ones: timer<=timer+1.
//   - mismatch[o]=1 and timer==all-ones:
//     - db_level[o]<=~db_level[o], timer_busy<=0;
//     - db_tick[o]<=1 if the new level is 1, else db_rel_tick[o]<=1.
//  Latency and timing
//   - Level changes exactly 2^TW edges after the grant edge.
//   - Uncontended total = 3 + 2^TW edges after sw changes: 2 sync edges + 1 grant edge.
//   - The release edge never grants. The earliest regrant is the following edge.
//   - The timer is therefore idle for exactly 1 cycle between owners.
//   - Ticks are high for exactly one cycle, and at most one tick bit is set per cycle.
//   - Non-owners only wait: their db_level is frozen, and requests that vanish before grant are dropped silently.
//   - Worst-case wait per key is (NKEYS-1)*(2^TW+1) cycles.
//   - A key that aborts goes behind the others, because ptr already moved past it.
//   - Timer width is exactly TW; the all-ones test prevents wrap. timer is don't-care while idle but is reset to 0.
//  States per key: stable (no mismatch), waiting (mismatch, not owner), timing (owner).
//  Controller states: IDLE and BUSY.
// TESTING (TW=4, NKEYS=4; edge 0 = first edge with sw changed)
//  1. sw[0] 0->1, held:
//     - grant at edge 3, timer_owner=0;
//     - db_level[0]=1 and db_tick[0]=1 after edge 19;
//     - tick low after edge 20; db_rel_tick stays 0.
//  2. sw[1] high for 6 cycles, then low:
//     - grant, then abort; timer_busy falls;
//     - db_level[1] stays 0; no ticks at all.
//  3. sw[0] and sw[2] rise together, ptr=0:
//     - key0 level at edge 19, key2 granted edge 20, key2 level at edge 36;
//     - timer_owner sequence 0 then 2.
//  4. Key0 debounced high, then sw[0] 1->0 held:
//     - db_rel_tick[0] one cycle after edge 19; db_level[0]=0; db_tick[0] stays 0.
//  5. Last owner 3 (ptr=0), all four keys mismatch:
//     - grant order 0,1,2,3; each level flips 17 edges after the previous.
//  6. rst asserted mid-count (timer=9, owner=1):
//     - after that edge: all outputs 0, timer_busy=0;
//     - key1 re-requests normally after rst is released.

Source files
------------

// File: rtl/debounce_timer_arbiter.sv
// Debounces NKEYS switch inputs with a single shared TW-bit timer.
// A round-robin arbiter lends the timer to one key at a time. A key requests
// the timer when its synchronised input differs from its debounced level.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   sw           raw asynchronous switch inputs
//   db_level     debounced level per key (registered)
//   db_tick      one-cycle pulse on a 0->1 debounced transition
//   db_rel_tick  one-cycle pulse on a 1->0 debounced transition
//   timer_busy   shared timer currently granted
//   timer_owner  index of the key holding the timer (valid when timer_busy)
module debounce_timer_arbiter #(
  parameter int unsigned NKEYS = 4,
  parameter int unsigned TW    = 19,
  localparam int unsigned OW   = $clog2(NKEYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] sw,
  output logic [NKEYS-1:0] db_level,
  output logic [NKEYS-1:0] db_tick,
  output logic [NKEYS-1:0] db_rel_tick,
  output logic             timer_busy,
  output logic [OW-1:0]    timer_owner
);

  typedef enum logic {StIdle, StBusy} state_e;

  logic [NKEYS-1:0] sync1_q, sync1_d;
  logic [NKEYS-1:0] sync2_q, sync2_d;
  logic [NKEYS-1:0] level_q, level_d;
  logic [NKEYS-1:0] tick_q, tick_d;
  logic [NKEYS-1:0] rel_q, rel_d;
  logic [TW-1:0]    timer_q, timer_d;
  state_e           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;

  logic [NKEYS-1:0] mismatch;
  logic             req_found;
  logic [OW-1:0]    req_idx;
  logic [OW-1:0]    req_next;
  logic [OW-1:0]    cand_idx;
  int unsigned      cand;

  assign mismatch = sync2_q ^ level_q;

  // Round-robin search: first requesting key at or above ptr, wrapping.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    req_next  = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NKEYS; k++) begin
      cand     = (32'(ptr_q) + k) % NKEYS;
      cand_idx = OW'(cand);
      if (!req_found && mismatch[cand_idx]) begin
        req_found = 1'b1;
        req_idx   = cand_idx;
        req_next  = OW'((cand + 1) % NKEYS);
      end
    end
  end

  always_comb begin
    sync1_d = sw;
    sync2_d = sync1_q;
    level_d = level_q;
    tick_d  = '0;
    rel_d   = '0;
    timer_d = timer_q;
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (req_found) begin
          timer_d = '0;
          owner_d = req_idx;
          ptr_d   = req_next;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!mismatch[owner_q]) begin
          // Input reverted before the timer expired: drop the grant.
          state_d = StIdle;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end else begin
          level_d[owner_q] = ~level_q[owner_q];
          if (!level_q[owner_q]) begin
            tick_d[owner_q] = 1'b1;
          end else begin
            rel_d[owner_q] = 1'b1;
          end
          // The release edge never grants; the next owner waits one cycle.
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      tick_q  <= '0;
      rel_q   <= '0;
      timer_q <= '0;
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      tick_q  <= tick_d;
      rel_q   <= rel_d;
      timer_q <= timer_d;
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign db_level    = level_q;
  assign db_tick     = tick_q;
  assign db_rel_tick = rel_q;
  assign timer_busy  = (state_q == StBusy);
  assign timer_owner = owner_q;

endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Bench for debounce_timer_arbiter (NKEYS=4, TW=4). Directed scenarios use
// fixed edge numbers; a randomized run compares every cycle against a model
// that tracks synchronised inputs, the current owner and the edges elapsed
// since its grant.
module tb_debounce_timer_arbiter;

  localparam int unsigned NKEYS = 4;
  localparam int unsigned TW    = 4;
  localparam int          HOLD  = 1 << TW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NKEYS-1:0] sw  = '0;
  logic [NKEYS-1:0] db_level;
  logic [NKEYS-1:0] db_tick;
  logic [NKEYS-1:0] db_rel_tick;
  logic             timer_busy;
  logic [1:0]       timer_owner;

  int n_checks = 0;
  int n_fail   = 0;

  debounce_timer_arbiter #(
    .NKEYS(NKEYS),
    .TW   (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .db_level   (db_level),
    .db_tick    (db_tick),
    .db_rel_tick(db_rel_tick),
    .timer_busy (timer_busy),
    .timer_owner(timer_owner)
  );

  always #5 clk = ~clk;

  // Reference model state.
  bit [NKEYS-1:0] m_s1, m_s2, m_level, m_tick, m_rel;
  bit             m_busy;
  int             m_owner, m_elapsed, m_ptr;

  task automatic model_edge();
    bit [NKEYS-1:0] want;
    bit             found;
    int             idx;
    want   = m_s2 ^ m_level;
    m_tick = '0;
    m_rel  = '0;
    if (rst) begin
      m_level = '0; m_busy = 0; m_owner = 0; m_elapsed = 0; m_ptr = 0;
      m_s1 = '0; m_s2 = '0;
    end else begin
      if (!m_busy) begin
        found = 0;
        for (int k = 0; k < NKEYS; k++) begin
          idx = (m_ptr + k) % NKEYS;
          if (!found && want[idx]) begin
            found = 1; m_busy = 1; m_owner = idx; m_elapsed = 0;
            m_ptr = (idx + 1) % NKEYS;
          end
        end
      end else if (!want[m_owner]) begin
        m_busy = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == HOLD) begin
          m_level[m_owner] = ~m_level[m_owner];
          if (m_level[m_owner]) m_tick[m_owner] = 1'b1;
          else m_rel[m_owner] = 1'b1;
          m_busy = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sw  = '0;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw  = '1;
    repeat (3) step();
    n_checks++;
    if (db_level !== 4'b0000) begin
      n_fail++; $display("FAIL reset_level: got %b want 0000", db_level);
    end
    n_checks++;
    if ((db_tick | db_rel_tick) !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ticks: got %b/%b want 0", db_tick, db_rel_tick);
    end
    n_checks++;
    if (timer_busy !== 1'b0 || timer_owner !== 2'd0) begin
      n_fail++; $display("FAIL reset_timer: got busy=%b owner=%0d want 0/0", timer_busy,
                         timer_owner);
    end
    sw = '0;
    step();
    rst = 1'b0;
    repeat (3) step();
  endtask

  // Key0 press, held: grant at edge 3, level/tick at edge 19.
  task automatic test_press();
    sw[0] = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      step();
      n_checks++;
      if (db_rel_tick !== 4'b0000) begin
        n_fail++; $display("FAIL press_rel e%0d: got %b want 0000", e, db_rel_tick);
      end
      if (e == 2 || e == 3) begin
        n_checks++;
        if (timer_busy !== (e == 3) || (e == 3 && timer_owner !== 2'd0)) begin
          n_fail++; $display("FAIL press_grant e%0d: got busy=%b owner=%0d", e, timer_busy,
                             timer_owner);
        end
      end
      if (e == 18 || e == 19) begin
        n_checks++;
        if (db_level[0] !== (e == 19) || db_tick !== ((e == 19) ? 4'b0001 : 4'b0000)) begin
          n_fail++; $display("FAIL press_level e%0d: got lvl=%b tick=%b", e, db_level, db_tick);
        end
      end
      if (e == 20) begin
        n_checks++;
        if (db_tick !== 4'b0000 || db_level !== 4'b0001) begin
          n_fail++; $display("FAIL press_tick_low: got tick=%b lvl=%b want 0000/0001", db_tick,
                             db_level);
        end
      end
    end
  endtask

  // Key1 high for 6 cycles: granted, then aborted with no level change.
  task automatic test_abort();
    sw[1] = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      step();
      if (e == 6) sw[1] = 1'b0;
      n_checks++;
      if (db_level !== 4'b0001 || (db_tick | db_rel_tick) !== 4'b0000) begin
        n_fail++; $display("FAIL abort_quiet e%0d: got lvl=%b tick=%b rel=%b", e, db_level,
                           db_tick, db_rel_tick);
      end
      if (e == 3 || e == 8 || e == 9) begin
        n_checks++;
        if (timer_busy !== (e != 9) || (e == 3 && timer_owner !== 2'd1)) begin
          n_fail++; $display("FAIL abort_busy e%0d: got busy=%b owner=%0d", e, timer_busy,
                             timer_owner);
        end
      end
    end
  endtask

  // Keys 0 and 2 together with ptr=0: 0 first, then 2 one cycle after release.
  task automatic test_two_keys();
    do_reset();
    sw = 4'b0101;
    for (int e = 1; e <= 38; e++) begin
      step();
      if (e == 3 || e == 20) begin
        n_checks++;
        if (timer_busy !== 1'b1 || timer_owner !== ((e == 3) ? 2'd0 : 2'd2)) begin
          n_fail++; $display("FAIL two_grant e%0d: got busy=%b owner=%0d", e, timer_busy,
                             timer_owner);
        end
      end
      if (e == 19) begin
        n_checks++;
        if (db_level !== 4'b0001 || db_tick !== 4'b0001 || timer_busy !== 1'b0) begin
          n_fail++; $display("FAIL two_key0 e19: got lvl=%b tick=%b busy=%b", db_level, db_tick,
                             timer_busy);
        end
      end
      if (e == 35 || e == 36) begin
        n_checks++;
        if (db_level !== ((e == 36) ? 4'b0101 : 4'b0001) ||
            db_tick !== ((e == 36) ? 4'b0100 : 4'b0000)) begin
          n_fail++; $display("FAIL two_key2 e%0d: got lvl=%b tick=%b", e, db_level, db_tick);
        end
      end
    end
  endtask

  // Key0 released after being debounced high.
  task automatic test_release();
    sw = 4'b0100;
    for (int e = 1; e <= 22; e++) begin
      step();
      n_checks++;
      if (db_tick !== 4'b0000) begin
        n_fail++; $display("FAIL rel_tick e%0d: got %b want 0000", e, db_tick);
      end
      if (e == 18 || e == 19 || e == 20) begin
        n_checks++;
        if (db_level !== ((e >= 19) ? 4'b0100 : 4'b0101) ||
            db_rel_tick !== ((e == 19) ? 4'b0001 : 4'b0000)) begin
          n_fail++; $display("FAIL rel_level e%0d: got lvl=%b rel=%b", e, db_level, db_rel_tick);
        end
      end
    end
  endtask

  // After owner 3 (ptr back to 0), all four keys mismatch: grants 0,1,2,3.
  task automatic test_round_robin();
    logic [3:0] exp_lvl;
    sw = 4'b1100;
    for (int e = 1; e <= 21; e++) begin
      step();
      if (e == 3) begin
        n_checks++;
        if (timer_busy !== 1'b1 || timer_owner !== 2'd3) begin
          n_fail++; $display("FAIL rr_setup: got busy=%b owner=%0d want 1/3", timer_busy,
                             timer_owner);
        end
      end
    end
    sw = 4'b0011;
    for (int e = 1; e <= 74; e++) begin
      step();
      for (int k = 0; k < 4; k++) begin
        if (e == 3 + 17 * k) begin
          n_checks++;
          if (timer_busy !== 1'b1 || timer_owner !== 2'(k)) begin
            n_fail++; $display("FAIL rr_grant k%0d: got busy=%b owner=%0d", k, timer_busy,
                               timer_owner);
          end
        end
        if (e == 18 + 17 * k || e == 19 + 17 * k) begin
          exp_lvl = 4'b1100 ^ 4'((1 << ((e == 19 + 17 * k) ? k + 1 : k)) - 1);
          n_checks++;
          if (db_level !== exp_lvl) begin
            n_fail++; $display("FAIL rr_level e%0d: got %b want %b", e, db_level, exp_lvl);
          end
        end
      end
    end
  endtask

  // Reset while key1 owns the timer at count 9, then key1 requests again.
  task automatic test_reset_mid();
    sw = 4'b0001;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 3) begin
        n_checks++;
        if (timer_busy !== 1'b1 || timer_owner !== 2'd1) begin
          n_fail++; $display("FAIL mid_grant: got busy=%b owner=%0d want 1/1", timer_busy,
                             timer_owner);
        end
      end
    end
    rst = 1'b1;
    sw  = 4'b0010;
    step();
    n_checks++;
    if (db_level !== 4'b0000 || (db_tick | db_rel_tick) !== 4'b0000 ||
        timer_busy !== 1'b0 || timer_owner !== 2'd0) begin
      n_fail++; $display("FAIL mid_reset: got lvl=%b tick=%b rel=%b busy=%b owner=%0d",
                         db_level, db_tick, db_rel_tick, timer_busy, timer_owner);
    end
    rst = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e == 3) begin
        n_checks++;
        if (timer_busy !== 1'b1 || timer_owner !== 2'd1) begin
          n_fail++; $display("FAIL mid_regrant: got busy=%b owner=%0d want 1/1", timer_busy,
                             timer_owner);
        end
      end
      if (e == 18 || e == 19) begin
        n_checks++;
        if (db_level !== ((e == 19) ? 4'b0010 : 4'b0000) ||
            db_tick !== ((e == 19) ? 4'b0010 : 4'b0000)) begin
          n_fail++; $display("FAIL mid_level e%0d: got lvl=%b tick=%b", e, db_level, db_tick);
        end
      end
    end
  endtask

  // Random flips and occasional resets, compared every cycle to the model.
  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      rst = 1'b0;
      if (r < 5) sw[$urandom_range(0, NKEYS - 1)] ^= 1'b1;
      else if (r == 99 && $urandom_range(0, 7) == 0) rst = 1'b1;
      step();
      n_checks++;
      if (db_level !== m_level || db_tick !== m_tick || db_rel_tick !== m_rel ||
          timer_busy !== m_busy || (m_busy && timer_owner !== 2'(m_owner))) begin
        n_fail++;
        $display("FAIL rand c%0d: got lvl=%b tk=%b rl=%b busy=%b own=%0d want %b %b %b %b %0d",
                 c, db_level, db_tick, db_rel_tick, timer_busy, timer_owner, m_level, m_tick,
                 m_rel, m_busy, m_owner);
      end
      n_checks++;
      if ($countones(db_tick | db_rel_tick) > 1) begin
        n_fail++; $display("FAIL rand_onehot c%0d: got tick=%b rel=%b want at most one bit", c,
                           db_tick, db_rel_tick);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press();
    test_abort();
    test_two_keys();
    test_release();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
